// File: rtl/piradip_mts_sysref_sequencer.sv
// rtl/piradip_mts_sysref_sequencer.sv - MTS bring-up: MMCM reset/lock retry, SYSREF period alignment, per-channel fan-out
module piradip_mts_sysref_sequencer #(
    parameter int NUM_CH       = 2,
    parameter int PERIOD_W     = 16,
    parameter int STABLE_COUNT = 4,
    parameter int RST_CYCLES   = 16,
    parameter int LOCK_TIMEOUT = 65535,
    parameter int MAX_RETRIES  = 3
) (
    input  logic                pl_clk,
    input  logic                reset,
    input  logic                sysref_in,
    input  logic                mmcm_locked,
    input  logic                start,
    input  logic                oneshot,
    input  logic [NUM_CH-1:0]   ch_enable,
    output logic                mmcm_rst,
    output logic [NUM_CH-1:0]   sysref_out,
    output logic [PERIOD_W-1:0] period,
    output logic [2:0]          state,
    output logic                aligned,
    output logic                fault,
    output logic                period_err
);

    localparam logic [2:0] ST_IDLE      = 3'd0;
    localparam logic [2:0] ST_MMCM_RST  = 3'd1;
    localparam logic [2:0] ST_WAIT_LOCK = 3'd2;
    localparam logic [2:0] ST_MEASURE   = 3'd3;
    localparam logic [2:0] ST_ALIGNED   = 3'd4;
    localparam logic [2:0] ST_DONE      = 3'd5;
    localparam logic [2:0] ST_FAULT     = 3'd6;

    localparam int RST_W   = $clog2(RST_CYCLES + 1);
    localparam int TO_W    = $clog2(LOCK_TIMEOUT + 1);
    localparam int RET_W   = (MAX_RETRIES < 1) ? 1 : $clog2(MAX_RETRIES + 1);
    localparam int MATCH_W = $clog2(STABLE_COUNT + 1);

    logic                sysref_d;
    logic [PERIOD_W-1:0] cnt;
    logic                edge_seen;
    logic                armed;
    logic                have_prev;
    logic [PERIOD_W-1:0] prev_meas;
    logic [PERIOD_W-1:0] lock_period;
    logic [MATCH_W-1:0]  match_cnt;
    logic [RST_W-1:0]    rst_cnt;
    logic [TO_W-1:0]     to_cnt;
    logic [RET_W-1:0]    retries;
    logic                oneshot_q;
    logic                os_fired;

    logic rise, cnt_sat, rst_done, to_done, can_retry, lock_fail;

    assign rise      = sysref_in & ~sysref_d;
    assign cnt_sat   = &cnt;
    assign rst_done  = (rst_cnt == RST_W'(RST_CYCLES - 1));
    assign to_done   = (to_cnt == TO_W'(LOCK_TIMEOUT - 1));
    assign can_retry = (retries < RET_W'(MAX_RETRIES));
    // Losing lock after measurement started is handled exactly like a lock timeout.
    assign lock_fail = !mmcm_locked &&
                       ((state == ST_WAIT_LOCK && to_done) ||
                        state == ST_MEASURE || state == ST_ALIGNED);

    assign mmcm_rst = (state == ST_MMCM_RST);
    assign aligned  = (state == ST_ALIGNED);
    assign fault    = (state == ST_FAULT);

    always_ff @(posedge pl_clk) begin
        if (reset) begin
            state       <= ST_IDLE;
            sysref_d    <= 1'b0;
            cnt         <= '0;
            edge_seen   <= 1'b0;
            armed       <= 1'b0;
            have_prev   <= 1'b0;
            prev_meas   <= '0;
            lock_period <= '0;
            match_cnt   <= '0;
            rst_cnt     <= '0;
            to_cnt      <= '0;
            retries     <= '0;
            oneshot_q   <= 1'b0;
            os_fired    <= 1'b0;
            period      <= '0;
            period_err  <= 1'b0;
            sysref_out  <= '0;
        end else begin
            sysref_d   <= sysref_in;
            sysref_out <= '0;
            if (rise) begin
                cnt       <= PERIOD_W'(1);
                edge_seen <= 1'b1;
            end else if (!cnt_sat) begin
                cnt <= cnt + 1'b1;
            end
            if (rise && edge_seen)
                period <= cnt;

            if (lock_fail) begin
                if (can_retry) begin
                    state   <= ST_MMCM_RST;
                    retries <= retries + 1'b1;
                    rst_cnt <= '0;
                end else begin
                    state <= ST_FAULT;
                end
            end else begin
                case (state)
                    ST_IDLE, ST_DONE, ST_FAULT: begin
                        if (start) begin
                            state      <= ST_MMCM_RST;
                            retries    <= '0;
                            rst_cnt    <= '0;
                            oneshot_q  <= oneshot;
                            os_fired   <= 1'b0;
                            period_err <= 1'b0;
                        end
                    end
                    ST_MMCM_RST: begin
                        if (rst_done) begin
                            state  <= ST_WAIT_LOCK;
                            to_cnt <= '0;
                        end else begin
                            rst_cnt <= rst_cnt + 1'b1;
                        end
                    end
                    ST_WAIT_LOCK: begin
                        if (mmcm_locked) begin
                            state     <= ST_MEASURE;
                            armed     <= 1'b0;
                            have_prev <= 1'b0;
                            match_cnt <= '0;
                        end else begin
                            to_cnt <= to_cnt + 1'b1;
                        end
                    end
                    ST_MEASURE: begin
                        // A saturated counter means the edge gap was unmeasurable; restart the run.
                        if (rise && (!armed || cnt_sat)) begin
                            armed     <= 1'b1;
                            have_prev <= 1'b0;
                            match_cnt <= '0;
                        end else if (rise) begin
                            if (!have_prev || cnt != prev_meas) begin
                                prev_meas <= cnt;
                                have_prev <= 1'b1;
                                match_cnt <= '0;
                            end else if (match_cnt == MATCH_W'(STABLE_COUNT - 1)) begin
                                state       <= ST_ALIGNED;
                                lock_period <= cnt;
                                os_fired    <= 1'b0;
                                match_cnt   <= '0;
                            end else begin
                                match_cnt <= match_cnt + 1'b1;
                            end
                        end else if (cnt_sat && armed) begin
                            armed     <= 1'b0;
                            have_prev <= 1'b0;
                            match_cnt <= '0;
                        end
                    end
                    ST_ALIGNED: begin
                        // One-shot leaves a cycle after the forwarded edge so its pulse stays inside ALIGNED.
                        if (oneshot_q && os_fired) begin
                            state <= ST_DONE;
                        end else if (rise) begin
                            if (cnt != lock_period) begin
                                period_err <= 1'b1;
                                state      <= ST_MEASURE;
                                armed      <= 1'b1;
                                have_prev  <= 1'b0;
                                match_cnt  <= '0;
                            end else begin
                                sysref_out <= ch_enable;
                                os_fired   <= oneshot_q;
                            end
                        end
                    end
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_piradip_mts_sysref_sequencer.sv
// tb/tb_piradip_mts_sysref_sequencer.sv - directed self-checking bench for the MTS SYSREF sequencer
module tb_piradip_mts_sysref_sequencer;

    logic        pl_clk = 1'b0;
    logic        reset, sysref_in, mmcm_locked, start, oneshot;
    logic [1:0]  ch_enable;
    logic        mmcm_rst, aligned, fault, period_err;
    logic [1:0]  sysref_out;
    logic [15:0] period;
    logic [2:0]  state;

    int errors = 0;
    int checks = 0;

    always #5 pl_clk = ~pl_clk;

    piradip_mts_sysref_sequencer #(
        .NUM_CH(2), .PERIOD_W(16), .STABLE_COUNT(4), .RST_CYCLES(16),
        .LOCK_TIMEOUT(100), .MAX_RETRIES(2)
    ) dut (
        .pl_clk(pl_clk), .reset(reset), .sysref_in(sysref_in), .mmcm_locked(mmcm_locked),
        .start(start), .oneshot(oneshot), .ch_enable(ch_enable), .mmcm_rst(mmcm_rst),
        .sysref_out(sysref_out), .period(period), .state(state), .aligned(aligned),
        .fault(fault), .period_err(period_err)
    );

    task automatic tick;
        @(posedge pl_clk);
        #1;
    endtask

    // One SYSREF rise, observed the cycle after the rise edge and one cycle later; p cycles to next rise.
    task automatic send_edge(input int p, output logic [1:0] so0, output logic [2:0] st0,
                             output logic [1:0] so1, output logic [2:0] st1);
        sysref_in = 1'b1;
        tick;
        so0 = sysref_out;
        st0 = state;
        tick;
        so1 = sysref_out;
        st1 = state;
        sysref_in = 1'b0;
        repeat (p - 2) tick;
    endtask

    task automatic do_reset;
        reset = 1'b1;
        tick;
        reset = 1'b0;
    endtask

    task automatic wait_rst_low(output int n);
        n = 0;
        while (mmcm_rst === 1'b1 && n < 200) begin
            n++;
            tick;
        end
    endtask

    task automatic bring_up(input logic os);
        logic [1:0] a, c;
        logic [2:0] b, d;
        int n;
        start = 1'b1;
        oneshot = os;
        tick;
        start = 1'b0;
        oneshot = 1'b0;
        wait_rst_low(n);
        repeat (3) tick;
        mmcm_locked = 1'b1;
        tick;
        for (int i = 0; i < 6; i++) send_edge(32, a, b, c, d);
    endtask

    task automatic count_pulses(output int n);
        logic prev;
        prev = 1'b0;
        n = 0;
        for (int k = 0; k < 3000 && state !== 3'd6; k++) begin
            if (mmcm_rst === 1'b1 && prev === 1'b0) n++;
            prev = mmcm_rst;
            tick;
        end
    endtask

    task automatic test_reset;
        reset = 1'b1;
        repeat (3) tick;
        checks++;
        if (state !== 3'd0) begin errors++; $display("FAIL reset_state: got %0d expected 0", state); end
        checks++;
        if ({mmcm_rst, sysref_out, aligned, fault, period_err} !== 6'b0) begin
            errors++;
            $display("FAIL reset_outputs: got %b expected 000000", {mmcm_rst, sysref_out, aligned, fault, period_err});
        end
        checks++;
        if (period !== 16'd0) begin errors++; $display("FAIL reset_period: got %0d expected 0", period); end
        reset = 1'b0;
        tick;
    endtask

    task automatic test_align;
        logic [1:0] so0, so1;
        logic [2:0] st0, st1;
        int n;
        ch_enable = 2'b11;
        start = 1'b1;
        tick;
        start = 1'b0;
        checks++;
        if (state !== 3'd1) begin errors++; $display("FAIL align_enter_rst: got %0d expected 1", state); end
        wait_rst_low(n);
        checks++;
        if (n !== 16) begin errors++; $display("FAIL align_rst_len: got %0d expected 16", n); end
        repeat (9) tick;
        checks++;
        if (state !== 3'd2) begin errors++; $display("FAIL align_wait_lock: got %0d expected 2", state); end
        mmcm_locked = 1'b1;
        tick;
        checks++;
        if (state !== 3'd3) begin errors++; $display("FAIL align_measure: got %0d expected 3", state); end
        for (int i = 1; i <= 8; i++) begin
            send_edge(32, so0, st0, so1, st1);
            if (i == 5) begin
                checks++;
                if (st0 !== 3'd3) begin errors++; $display("FAIL align_not_yet: got %0d expected 3", st0); end
            end
            if (i == 6) begin
                checks++;
                if (st0 !== 3'd4 || so0 !== 2'b00) begin
                    errors++;
                    $display("FAIL align_6th_rise: got state %0d out %b expected state 4 out 00", st0, so0);
                end
            end
            if (i >= 7) begin
                checks++;
                if (so0 !== 2'b11 || so1 !== 2'b00 || st0 !== 3'd4) begin
                    errors++;
                    $display("FAIL align_pulse: got %b/%b state %0d expected 11/00 state 4", so0, so1, st0);
                end
            end
        end
        checks++;
        if (period !== 16'd32) begin errors++; $display("FAIL align_period: got %0d expected 32", period); end
    endtask

    task automatic test_reset_mid_aligned;
        sysref_in = 1'b1;
        reset = 1'b1;
        tick;
        checks++;
        if (state !== 3'd0 || sysref_out !== 2'b00 || aligned !== 1'b0 || mmcm_rst !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_aligned: got state %0d out %b aligned %b expected 0 00 0", state, sysref_out, aligned);
        end
        checks++;
        if (period !== 16'd0 || period_err !== 1'b0 || fault !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_regs: got period %0d err %b fault %b expected 0 0 0", period, period_err, fault);
        end
        reset = 1'b0;
        sysref_in = 1'b0;
        tick;
    endtask

    task automatic test_oneshot;
        logic [1:0] so0, so1;
        logic [2:0] st0, st1;
        do_reset;
        ch_enable = 2'b10;
        bring_up(1'b1);
        checks++;
        if (state !== 3'd4) begin errors++; $display("FAIL oneshot_aligned: got %0d expected 4", state); end
        send_edge(32, so0, st0, so1, st1);
        checks++;
        if (so0 !== 2'b10 || st0 !== 3'd4) begin
            errors++;
            $display("FAIL oneshot_pulse: got out %b state %0d expected 10 state 4", so0, st0);
        end
        checks++;
        if (so1 !== 2'b00 || st1 !== 3'd5) begin
            errors++;
            $display("FAIL oneshot_done: got out %b state %0d expected 00 state 5", so1, st1);
        end
        send_edge(32, so0, st0, so1, st1);
        checks++;
        if (so0 !== 2'b00 || st0 !== 3'd5) begin
            errors++;
            $display("FAIL oneshot_hold: got out %b state %0d expected 00 state 5", so0, st0);
        end
        start = 1'b1;
        tick;
        start = 1'b0;
        checks++;
        if (state !== 3'd1) begin errors++; $display("FAIL oneshot_restart: got %0d expected 1", state); end
    endtask

    task automatic test_period_err;
        logic [1:0] so0, so1;
        logic [2:0] st0, st1;
        int n;
        int plist[12] = '{32, 32, 33, 32, 32, 32, 32, 32, 32, 40, 32, 32};
        do_reset;
        ch_enable = 2'b11;
        start = 1'b1;
        tick;
        start = 1'b0;
        wait_rst_low(n);
        tick;
        for (int i = 0; i < 12; i++) begin
            send_edge(plist[i], so0, st0, so1, st1);
            if (i == 3) begin
                checks++;
                if (period !== 16'd33 || st0 !== 3'd3) begin
                    errors++;
                    $display("FAIL perr_33: got period %0d state %0d expected 33 state 3", period, st0);
                end
            end
            if (i == 7) begin
                checks++;
                if (st0 !== 3'd3) begin errors++; $display("FAIL perr_not_aligned: got %0d expected 3", st0); end
            end
            if (i == 8) begin
                checks++;
                if (st0 !== 3'd4) begin errors++; $display("FAIL perr_aligned: got %0d expected 4", st0); end
            end
            if (i == 9) begin
                checks++;
                if (so0 !== 2'b11) begin errors++; $display("FAIL perr_pulse: got %b expected 11", so0); end
            end
            if (i == 10) begin
                checks++;
                if (st0 !== 3'd3 || so0 !== 2'b00 || so1 !== 2'b00 || period_err !== 1'b1 || period !== 16'd40) begin
                    errors++;
                    $display("FAIL perr_40: got state %0d out %b/%b err %b period %0d expected 3 00/00 1 40",
                             st0, so0, so1, period_err, period);
                end
            end
            if (i == 11) begin
                checks++;
                if (period_err !== 1'b1) begin errors++; $display("FAIL perr_sticky: got %b expected 1", period_err); end
            end
        end
    endtask

    task automatic test_lock_loss;
        int n;
        do_reset;
        ch_enable = 2'b11;
        bring_up(1'b0);
        checks++;
        if (aligned !== 1'b1) begin errors++; $display("FAIL loss_pre_aligned: got %b expected 1", aligned); end
        mmcm_locked = 1'b0;
        tick;
        checks++;
        if (aligned !== 1'b0 || mmcm_rst !== 1'b1 || state !== 3'd1) begin
            errors++;
            $display("FAIL loss_reaction: got aligned %b rst %b state %0d expected 0 1 1", aligned, mmcm_rst, state);
        end
        count_pulses(n);
        checks++;
        if (n !== 2 || state !== 3'd6) begin
            errors++;
            $display("FAIL loss_retry_count: got %0d pulses state %0d expected 2 pulses state 6", n, state);
        end
    endtask

    task automatic test_timeout;
        int n;
        do_reset;
        mmcm_locked = 1'b0;
        start = 1'b1;
        tick;
        start = 1'b0;
        count_pulses(n);
        checks++;
        if (n !== 3) begin errors++; $display("FAIL timeout_pulses: got %0d expected 3", n); end
        checks++;
        if (fault !== 1'b1 || state !== 3'd6 || aligned !== 1'b0) begin
            errors++;
            $display("FAIL timeout_fault: got fault %b state %0d expected 1 6", fault, state);
        end
        start = 1'b1;
        tick;
        start = 1'b0;
        checks++;
        if (state !== 3'd1 || fault !== 1'b0) begin
            errors++;
            $display("FAIL fault_restart: got state %0d fault %b expected 1 0", state, fault);
        end
    endtask

    initial begin
        reset = 1'b1;
        sysref_in = 1'b0;
        mmcm_locked = 1'b0;
        start = 1'b0;
        oneshot = 1'b0;
        ch_enable = 2'b00;
        test_reset;
        test_align;
        test_reset_mid_aligned;
        test_oneshot;
        test_period_err;
        test_lock_loss;
        test_timeout;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
